// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader
//
// Boot-time writer for the word-addressed instruction memory. A load request
// (start, start_addr, word_cnt) is range-checked against the IM window. Once it
// is accepted, the loader collects a big-endian byte stream into 32-bit words
// and writes each word at consecutive word addresses. busy holds the CPU off
// while a load runs, done pulses at the end, and err flags a rejected request.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle load request, sampled only while idle
//   start_addr  first word address (byte address bits [15:2])
//   word_cnt    number of words to load, 0 is legal
//   in_valid    in_byte carries a byte this cycle
//   in_byte     stream byte, first byte is the MSB of a word
//   in_ready    loader accepts a byte this cycle
//   we          IM write enable, one pulse per word
//   waddr       IM write word address
//   wdata       IM write data
//   busy        load in progress
//   done        one-cycle pulse after the last word (or a zero-length load)
//   err         sticky range error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module im_loader #(
  parameter logic [13:0] BASE_WORD = 14'h0c00,
  parameter int          DEPTH     = 2048,
  parameter int          CNT_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [13:0]      start_addr,
  input  logic [CNT_W-1:0] word_cnt,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             we,
  output logic [13:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // The sum of offset and count must not wrap, so it is one bit wider than
  // the wider of its two operands.
  localparam int               SUM_W   = ((CNT_W > 14) ? CNT_W : 14) + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // A start_addr below BASE_WORD wraps to a huge offset, so it is rejected
  // by the same comparison that catches overruns past the top.
  function automatic logic range_ok(input logic [13:0]      addr,
                                    input logic [CNT_W-1:0] cnt);
    logic [13:0]      off;
    logic [SUM_W-1:0] last;
    off  = addr - BASE_WORD;
    last = SUM_W'(off) + SUM_W'(cnt);
    return (last <= DEPTH_S);
  endfunction

  // Insert byte number idx into its big-endian lane of the word.
  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r        = word;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [13:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      shift_q, shift_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      word_next;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    // done follows FIN by one edge, so it rises together with busy falling.
    done_d      = (state_q == ST_FIN);
    word_next   = place_byte(shift_q, byte_idx_q, in_byte);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!range_ok(start_addr, word_cnt)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (word_cnt == {CNT_W{1'b0}}) begin
            err_d   = 1'b0;
            state_d = ST_FIN;
          end else begin
            err_d       = 1'b0;
            waddr_d     = start_addr;
            remaining_d = word_cnt;
            byte_idx_d  = 2'd0;
            shift_d     = 32'h0000_0000;
            busy_d      = 1'b1;
            state_d     = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          if (byte_idx_q == 2'd3) begin
            wdata_d    = word_next;
            shift_d    = 32'h0000_0000;
            byte_idx_d = 2'd0;
            we_d       = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            shift_d    = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_WRITE: begin
        waddr_d     = waddr_q + 14'd1;
        remaining_d = remaining_q - CNT_ONE;
        byte_idx_d  = 2'd0;
        if (remaining_q == CNT_ONE) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      waddr_q     <= 14'h0000;
      wdata_q     <= 32'h0000_0000;
      shift_q     <= 32'h0000_0000;
      remaining_q <= {CNT_W{1'b0}};
      byte_idx_q  <= 2'd0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
